// File: rtl/shared_ram_arbiter_if.sv
// Bus bundle between the shared RAM arbiter and its environment.
// Carries the CPU word port (valid/ready, wstrb), NPORTS byte-wide
// peripheral ports (ren/wen/gnt/rvalid) and the four-lane RAM interface.
// slave  : arbiter side
// master : environment side (CPU decoder, peripherals, RAM)
interface shared_ram_arbiter_if #(
  parameter int AW     = 10,
  parameter int NPORTS = 2
);
  logic                   i_cpu_valid;
  logic [AW-1:0]          i_cpu_addr;
  logic [31:0]            i_cpu_wdata;
  logic [3:0]             i_cpu_wstrb;
  logic                   o_cpu_ready;
  logic [31:0]            o_cpu_rdata;
  logic [NPORTS-1:0]      i_bp_ren;
  logic [NPORTS-1:0]      i_bp_wen;
  logic [NPORTS*AW-1:0]   i_bp_addr;
  logic [NPORTS*8-1:0]    i_bp_wdata;
  logic [NPORTS-1:0]      o_bp_gnt;
  logic [NPORTS-1:0]      o_bp_rvalid;
  logic [NPORTS*8-1:0]    o_bp_rdata;
  logic                   o_ram_ce;
  logic [AW-3:0]          o_ram_addr;
  logic [31:0]            o_ram_wdata;
  logic [3:0]             o_ram_we;
  logic [31:0]            i_ram_rdata;

  modport slave (
    input  i_cpu_valid, i_cpu_addr, i_cpu_wdata, i_cpu_wstrb,
    output o_cpu_ready, o_cpu_rdata,
    input  i_bp_ren, i_bp_wen, i_bp_addr, i_bp_wdata,
    output o_bp_gnt, o_bp_rvalid, o_bp_rdata,
    output o_ram_ce, o_ram_addr, o_ram_wdata, o_ram_we,
    input  i_ram_rdata
  );

  modport master (
    output i_cpu_valid, i_cpu_addr, i_cpu_wdata, i_cpu_wstrb,
    input  o_cpu_ready, o_cpu_rdata,
    output i_bp_ren, i_bp_wen, i_bp_addr, i_bp_wdata,
    input  o_bp_gnt, o_bp_rvalid, o_bp_rdata,
    input  o_ram_ce, o_ram_addr, o_ram_wdata, o_ram_we,
    output i_ram_rdata
  );
endinterface

// File: rtl/shared_ram_arbiter.sv
// Shares one single-port 32-bit RAM (four byte lanes, 1-cycle read latency)
// between a CPU word port and NPORTS byte-wide peripheral ports.
// Byte ports win over the CPU unless the CPU has been denied MAX_WAIT
// consecutive cycles. Byte ports are served round-robin (RR=1) or by
// fixed lowest-index priority (RR=0).
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - shared_ram_arbiter_if.slave: CPU port, byte ports, RAM lanes
module shared_ram_arbiter #(
  parameter int AW       = 10,
  parameter int NPORTS   = 2,
  parameter bit RR       = 1'b1,
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  shared_ram_arbiter_if.slave bus
);
  localparam int          PW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
  localparam int unsigned NP = NPORTS;

  logic              cpu_ready_q;
  logic              cpu_pend;
  logic [3:0]        wait_cnt;
  logic [PW-1:0]     rr_ptr;
  logic [NPORTS-1:0] rvalid_q;
  logic [1:0]        rd_lane;

  logic [NPORTS-1:0] bp_req;
  logic              any_req;
  logic              cpu_elig;
  logic              force_cpu;
  logic              grant_cpu;
  logic              grant_bp;
  logic [PW-1:0]     sel;
  logic              sel_found;
  int unsigned       idx;
  logic [AW-1:0]     sel_addr;
  logic [7:0]        sel_wdata;
  logic              sel_wen;
  logic [7:0]        lane_byte;

  assign bp_req   = bus.i_bp_ren | bus.i_bp_wen;
  assign any_req  = |bp_req;
  // A CPU transaction is eligible only until it has been granted once;
  // cpu_pend covers the grant cycle's successor so the RAM is hit exactly once.
  assign cpu_elig  = bus.i_cpu_valid & ~cpu_ready_q & ~cpu_pend;
  assign force_cpu = cpu_elig & (wait_cnt == 4'(MAX_WAIT));
  assign grant_cpu = ~rst & cpu_elig & (force_cpu | ~any_req);
  assign grant_bp  = ~rst & any_req & ~force_cpu;

  // Byte-port selection: scan from rr_ptr (round-robin) or from 0 (fixed).
  always_comb begin
    sel       = '0;
    sel_found = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NP; i++) begin
      idx = RR ? ((32'(rr_ptr) + i) % NP) : i;
      if (!sel_found && bp_req[idx]) begin
        sel       = idx[PW-1:0];
        sel_found = 1'b1;
      end
    end
  end

  assign sel_addr  = bus.i_bp_addr[sel*AW +: AW];
  assign sel_wdata = bus.i_bp_wdata[sel*8 +: 8];
  assign sel_wen   = bus.i_bp_wen[sel];

  always_comb begin
    bus.o_bp_gnt    = '0;
    bus.o_ram_ce    = 1'b0;
    bus.o_ram_addr  = '0;
    bus.o_ram_wdata = '0;
    bus.o_ram_we    = '0;
    if (grant_cpu) begin
      bus.o_ram_ce    = 1'b1;
      bus.o_ram_addr  = bus.i_cpu_addr[AW-1:2];
      bus.o_ram_wdata = bus.i_cpu_wdata;
      bus.o_ram_we    = bus.i_cpu_wstrb;
    end else if (grant_bp) begin
      bus.o_bp_gnt[sel] = 1'b1;
      bus.o_ram_ce      = 1'b1;
      bus.o_ram_addr    = sel_addr[AW-1:2];
      if (sel_wen) begin
        bus.o_ram_wdata = {4{sel_wdata}};
        bus.o_ram_we    = 4'b0001 << sel_addr[1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_ready_q <= 1'b0;
      cpu_pend    <= 1'b0;
      wait_cnt    <= '0;
      rr_ptr      <= '0;
      rvalid_q    <= '0;
      rd_lane     <= '0;
    end else begin
      cpu_ready_q <= grant_cpu;
      if (grant_cpu)
        cpu_pend <= 1'b1;
      else if (cpu_ready_q)
        cpu_pend <= 1'b0;

      if (grant_cpu || !bus.i_cpu_valid)
        wait_cnt <= '0;
      else if (cpu_elig && (wait_cnt < 4'(MAX_WAIT)))
        wait_cnt <= wait_cnt + 4'd1;

      rvalid_q <= '0;
      if (grant_bp) begin
        rr_ptr <= (sel == PW'(NPORTS - 1)) ? '0 : sel + 1'b1;
        if (!sel_wen) begin
          rvalid_q[sel] <= 1'b1;
          rd_lane       <= sel_addr[1:0];
        end
      end
    end
  end

  // Completions are masked during reset so an in-flight access reports nothing.
  assign lane_byte       = bus.i_ram_rdata[rd_lane*8 +: 8];
  assign bus.o_cpu_ready = cpu_ready_q & ~rst;
  assign bus.o_cpu_rdata = rst ? '0 : bus.i_ram_rdata;
  assign bus.o_bp_rvalid = rst ? '0 : rvalid_q;
  assign bus.o_bp_rdata  = rst ? '0 : {NPORTS{lane_byte}};
endmodule

// File: tb/tb_shared_ram_arbiter.sv
// Directed bench for shared_ram_arbiter: a round-robin instance backed by a
// behavioural 4-lane RAM, plus a fixed-priority instance for grant order.
module tb_shared_ram_arbiter;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  shared_ram_arbiter_if #(.AW(10), .NPORTS(2)) bus ();
  shared_ram_arbiter_if #(.AW(10), .NPORTS(2)) bus_fx ();

  shared_ram_arbiter #(.AW(10), .NPORTS(2), .RR(1'b1), .MAX_WAIT(4)) u_dut (
    .clk(clk), .rst(rst), .bus(bus.slave));

  shared_ram_arbiter #(.AW(10), .NPORTS(2), .RR(1'b0), .MAX_WAIT(4)) u_fx (
    .clk(clk), .rst(rst), .bus(bus_fx.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: registered read of the old word, per-lane writes
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (bus.o_ram_ce) begin
      for (int l = 0; l < 4; l++)
        if (bus.o_ram_we[l]) mem[bus.o_ram_addr][l*8 +: 8] <= bus.o_ram_wdata[l*8 +: 8];
      bus.i_ram_rdata <= mem[bus.o_ram_addr];
    end
  end
  assign bus_fx.i_ram_rdata = '0;

  task automatic idle_inputs();
    bus.i_cpu_valid = 1'b0; bus.i_cpu_addr = '0; bus.i_cpu_wdata = '0; bus.i_cpu_wstrb = '0;
    bus.i_bp_ren = '0; bus.i_bp_wen = '0; bus.i_bp_addr = '0; bus.i_bp_wdata = '0;
    bus_fx.i_cpu_valid = 1'b0; bus_fx.i_cpu_addr = '0; bus_fx.i_cpu_wdata = '0; bus_fx.i_cpu_wstrb = '0;
    bus_fx.i_bp_ren = '0; bus_fx.i_bp_wen = '0; bus_fx.i_bp_addr = '0; bus_fx.i_bp_wdata = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.i_bp_ren = 2'b01;
    bus_fx.i_bp_ren = 2'b01;
    repeat (2) @(negedge clk);
    #4;
    checks++; if (bus.o_bp_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", bus.o_bp_gnt); end
    checks++; if (bus_fx.o_bp_gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt_fx: got %b want 00", bus_fx.o_bp_gnt); end
    checks++; if (bus.o_ram_ce !== 1'b0) begin errors++; $display("FAIL reset_ce: got %b want 0", bus.o_ram_ce); end
    checks++; if (bus.o_cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b want 0", bus.o_cpu_ready); end
    checks++; if (bus.o_bp_rvalid !== 2'b00) begin errors++; $display("FAIL reset_rvalid: got %b want 00", bus.o_bp_rvalid); end
    @(negedge clk);
    rst = 1'b0;
    idle_inputs();
  endtask

  task automatic test_cpu();
    @(negedge clk);
    bus.i_cpu_valid = 1'b1; bus.i_cpu_addr = 10'h010; bus.i_cpu_wdata = 32'h1000_0000; bus.i_cpu_wstrb = 4'hF;
    #4;
    checks++; if (bus.o_ram_ce !== 1'b1) begin errors++; $display("FAIL cpu_wr_ce: got %b want 1", bus.o_ram_ce); end
    checks++; if (bus.o_ram_addr !== 8'h04) begin errors++; $display("FAIL cpu_wr_addr: got %h want 04", bus.o_ram_addr); end
    checks++; if (bus.o_ram_we !== 4'hF) begin errors++; $display("FAIL cpu_wr_we: got %h want F", bus.o_ram_we); end
    checks++; if (bus.o_ram_wdata !== 32'h1000_0000) begin errors++; $display("FAIL cpu_wr_wdata: got %h want 10000000", bus.o_ram_wdata); end
    checks++; if (bus.o_cpu_ready !== 1'b0) begin errors++; $display("FAIL cpu_wr_ready_early: got %b want 0", bus.o_cpu_ready); end
    @(negedge clk); #4;
    checks++; if (bus.o_cpu_ready !== 1'b1) begin errors++; $display("FAIL cpu_wr_ready: got %b want 1", bus.o_cpu_ready); end
    checks++; if (bus.o_ram_ce !== 1'b0) begin errors++; $display("FAIL cpu_wr_no_repeat: got %b want 0", bus.o_ram_ce); end
    @(negedge clk);
    bus.i_cpu_wstrb = 4'h0; bus.i_cpu_wdata = '0;
    #4;
    checks++; if (bus.o_ram_ce !== 1'b1 || bus.o_ram_we !== 4'h0) begin errors++; $display("FAIL cpu_rd_access: got ce=%b we=%h want ce=1 we=0", bus.o_ram_ce, bus.o_ram_we); end
    @(negedge clk); #4;
    checks++; if (bus.o_cpu_ready !== 1'b1) begin errors++; $display("FAIL cpu_rd_ready: got %b want 1", bus.o_cpu_ready); end
    checks++; if (bus.o_cpu_rdata !== 32'h1000_0000) begin errors++; $display("FAIL cpu_rd_data: got %h want 10000000", bus.o_cpu_rdata); end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_byte();
    @(negedge clk);
    bus.i_bp_wen = 2'b01; bus.i_bp_addr = {10'h000, 10'h013}; bus.i_bp_wdata = 16'h00AB;
    #4;
    checks++; if (bus.o_bp_gnt !== 2'b01) begin errors++; $display("FAIL bw_gnt: got %b want 01", bus.o_bp_gnt); end
    checks++; if (bus.o_ram_we !== 4'b1000) begin errors++; $display("FAIL bw_we: got %b want 1000", bus.o_ram_we); end
    checks++; if (bus.o_ram_addr !== 8'h04) begin errors++; $display("FAIL bw_addr: got %h want 04", bus.o_ram_addr); end
    checks++; if (bus.o_ram_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL bw_wdata: got %h want ABABABAB", bus.o_ram_wdata); end
    @(negedge clk);
    bus.i_bp_wen = 2'b00; bus.i_bp_ren = 2'b01;
    #4;
    checks++; if (bus.o_bp_gnt !== 2'b01 || bus.o_ram_we !== 4'h0) begin errors++; $display("FAIL br_gnt: got gnt=%b we=%h want gnt=01 we=0", bus.o_bp_gnt, bus.o_ram_we); end
    checks++; if (bus.o_bp_rvalid !== 2'b00) begin errors++; $display("FAIL br_rvalid_early: got %b want 00", bus.o_bp_rvalid); end
    @(negedge clk);
    bus.i_bp_ren = 2'b00;
    #4;
    checks++; if (bus.o_bp_rvalid !== 2'b01) begin errors++; $display("FAIL br_rvalid: got %b want 01", bus.o_bp_rvalid); end
    checks++; if (bus.o_bp_rdata[7:0] !== 8'hAB) begin errors++; $display("FAIL br_rdata: got %h want AB", bus.o_bp_rdata[7:0]); end
    idle_inputs();
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_gnt;
    logic [1:0] prev_gnt;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    bus.i_bp_ren = 2'b11; bus.i_bp_addr = {10'h012, 10'h013};
    bus_fx.i_bp_ren = 2'b11; bus_fx.i_bp_addr = {10'h012, 10'h013};
    prev_gnt = 2'b00;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      #4;
      exp_gnt = (c % 2 == 0) ? 2'b01 : 2'b10;
      checks++; if (bus.o_bp_gnt !== exp_gnt) begin errors++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, bus.o_bp_gnt, exp_gnt); end
      checks++; if (bus_fx.o_bp_gnt !== 2'b01) begin errors++; $display("FAIL fixed_gnt[%0d]: got %b want 01", c, bus_fx.o_bp_gnt); end
      if (c > 0) begin
        checks++; if (bus.o_bp_rvalid !== prev_gnt) begin errors++; $display("FAIL rr_rvalid[%0d]: got %b want %b", c, bus.o_bp_rvalid, prev_gnt); end
      end
      if (c == 1) begin
        checks++; if (bus.o_bp_rdata[7:0] !== 8'hAB) begin errors++; $display("FAIL rr_rdata0: got %h want AB", bus.o_bp_rdata[7:0]); end
      end
      prev_gnt = exp_gnt;
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_starvation();
    @(negedge clk);
    bus.i_bp_wen = 2'b01; bus.i_bp_addr = {10'h000, 10'h020}; bus.i_bp_wdata = 16'h0011;
    bus.i_cpu_valid = 1'b1; bus.i_cpu_addr = 10'h010; bus.i_cpu_wstrb = 4'h0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) @(negedge clk);
      #4;
      if (c == 5) begin
        checks++; if (bus.o_bp_gnt !== 2'b00 || bus.o_ram_ce !== 1'b1 || bus.o_ram_addr !== 8'h04) begin
          errors++; $display("FAIL starve_cpu_grant: got gnt=%b ce=%b addr=%h want gnt=00 ce=1 addr=04", bus.o_bp_gnt, bus.o_ram_ce, bus.o_ram_addr); end
      end else begin
        checks++; if (bus.o_bp_gnt !== 2'b01) begin errors++; $display("FAIL starve_port_gnt[%0d]: got %b want 01", c, bus.o_bp_gnt); end
      end
      checks++; if (bus.o_cpu_ready !== (c == 6)) begin errors++; $display("FAIL starve_ready[%0d]: got %b want %b", c, bus.o_cpu_ready, (c == 6)); end
      if (c == 6) begin
        checks++; if (bus.o_cpu_rdata !== 32'hAB00_0000) begin errors++; $display("FAIL starve_rdata: got %h want AB000000", bus.o_cpu_rdata); end
      end
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_cpu_vs_port();
    @(negedge clk);
    bus.i_bp_wen = 2'b10; bus.i_bp_addr = {10'h031, 10'h000}; bus.i_bp_wdata = 16'h5C00;
    bus.i_cpu_valid = 1'b1; bus.i_cpu_addr = 10'h040; bus.i_cpu_wdata = 32'h1234_5678; bus.i_cpu_wstrb = 4'h3;
    #4;
    checks++; if (bus.o_bp_gnt !== 2'b10) begin errors++; $display("FAIL cvp_port_gnt: got %b want 10", bus.o_bp_gnt); end
    checks++; if (bus.o_ram_we !== 4'b0010 || bus.o_ram_addr !== 8'h0C) begin errors++; $display("FAIL cvp_port_access: got we=%b addr=%h want we=0010 addr=0C", bus.o_ram_we, bus.o_ram_addr); end
    checks++; if (bus.o_ram_wdata !== 32'h5C5C_5C5C) begin errors++; $display("FAIL cvp_port_wdata: got %h want 5C5C5C5C", bus.o_ram_wdata); end
    @(negedge clk);
    bus.i_bp_wen = 2'b00;
    #4;
    checks++; if (bus.o_bp_gnt !== 2'b00 || bus.o_ram_ce !== 1'b1) begin errors++; $display("FAIL cvp_cpu_grant: got gnt=%b ce=%b want gnt=00 ce=1", bus.o_bp_gnt, bus.o_ram_ce); end
    checks++; if (bus.o_ram_we !== 4'h3 || bus.o_ram_addr !== 8'h10 || bus.o_ram_wdata !== 32'h1234_5678) begin
      errors++; $display("FAIL cvp_cpu_access: got we=%h addr=%h wdata=%h want we=3 addr=10 wdata=12345678", bus.o_ram_we, bus.o_ram_addr, bus.o_ram_wdata); end
    checks++; if (bus.o_cpu_ready !== 1'b0) begin errors++; $display("FAIL cvp_ready_early: got %b want 0", bus.o_cpu_ready); end
    @(negedge clk); #4;
    checks++; if (bus.o_cpu_ready !== 1'b1) begin errors++; $display("FAIL cvp_ready: got %b want 1", bus.o_cpu_ready); end
    checks++; if (bus.o_ram_ce !== 1'b0) begin errors++; $display("FAIL cvp_single_access: got ce=%b want 0", bus.o_ram_ce); end
    @(negedge clk);
    idle_inputs();
    #4;
    checks++; if (bus.o_cpu_ready !== 1'b0 || bus.o_ram_ce !== 1'b0) begin errors++; $display("FAIL cvp_idle: got ready=%b ce=%b want 0 0", bus.o_cpu_ready, bus.o_ram_ce); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.i_bp_ren = 2'b01; bus.i_bp_addr = {10'h000, 10'h013};
    #4;
    checks++; if (bus.o_bp_gnt !== 2'b01) begin errors++; $display("FAIL rm_gnt: got %b want 01", bus.o_bp_gnt); end
    @(negedge clk);
    rst = 1'b1;
    #4;
    checks++; if (bus.o_bp_rvalid !== 2'b00) begin errors++; $display("FAIL rm_rvalid_dropped: got %b want 00", bus.o_bp_rvalid); end
    checks++; if (bus.o_bp_gnt !== 2'b00 || bus.o_ram_ce !== 1'b0) begin errors++; $display("FAIL rm_gnt_in_reset: got gnt=%b ce=%b want 00 0", bus.o_bp_gnt, bus.o_ram_ce); end
    @(negedge clk);
    rst = 1'b0;
    bus.i_bp_ren = 2'b11; bus.i_bp_addr = {10'h012, 10'h013};
    #4;
    checks++; if (bus.o_bp_gnt !== 2'b01) begin errors++; $display("FAIL rm_rr_ptr_cleared: got %b want 01", bus.o_bp_gnt); end
    checks++; if (bus.o_bp_rvalid !== 2'b00) begin errors++; $display("FAIL rm_rvalid_after: got %b want 00", bus.o_bp_rvalid); end
    @(negedge clk);
    idle_inputs();
    #4;
    checks++; if (bus.o_bp_rvalid !== 2'b01 || bus.o_bp_rdata[7:0] !== 8'hAB) begin
      errors++; $display("FAIL rm_read_after: got rvalid=%b rdata=%h want 01 AB", bus.o_bp_rvalid, bus.o_bp_rdata[7:0]); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_cpu();
    test_byte();
    test_round_robin();
    test_starvation();
    test_cpu_vs_port();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
